rt8_col_seq: RTL and testbench



---
 rtl/rt8_seq_pkg.sv | 34 +++
 rtl/rt8_apx_slice.sv | 44 ++++
 rtl/rt8_col_seq.sv | 190 +++++++++++++++++++
 tb/tb_rt8_col_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rt8_seq_pkg.sv
// Shared types and constants for the rt8 column-serial reduction slice.
// Holds the scheduler state enum, the column-to-compressor bit mapping,
// the error-flag bit positions and the approximate 4:2 compressor function.
package rt8_seq_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int unsigned COL_W  = 8;   // bits per operand column
   localparam int unsigned CMP_W  = 4;   // inputs per 4:2 compressor
   localparam int unsigned U0_LSB = 0;   // s_col[3:0] -> U0 x1..x4
   localparam int unsigned U1_LSB = 4;   // s_col[7:4] -> U1 x1..x4

   localparam int unsigned ERR_W  = 3;
   localparam int unsigned ERR_U0 = 2;
   localparam int unsigned ERR_U1 = 1;
   localparam int unsigned ERR_U2 = 0;

   // Approximate 4:2 cell, x[0]=x1 .. x[3]=x4; returns {err, summ, carry}.
   function automatic logic [2:0] apx42(input logic [CMP_W-1:0] x);
      logic err;
      logic summ;
      logic carry;
      err   = &x;
      summ  = (^x) | err;
      carry = ((x[0] ^ x[1]) & (x[2] ^ x[3])) |
              ((x[0] & x[1]) ^ (x[2] & x[3])) | err;
      return {err, summ, carry};
   endfunction

endpackage

// File: rtl/rt8_apx_slice.sv
// Combinational three-compressor tree for one 8-bit column.
// Ports:
//   x_i[7:0]          column bits (U0 on [3:0], U1 on [7:4])
//   cin1_i, cin2_i    carries from the previous column
//   cout1_o, cout2_o  U0/U1 carries for the next column
//   sum_o, carry_o    U2 outputs
//   u_err_o[2:0]      {U0_err, U1_err, U2_err}
module rt8_apx_slice
   import rt8_seq_pkg::*;
(
   input  logic [COL_W-1:0] x_i,
   input  logic             cin1_i,
   input  logic             cin2_i,
   output logic             cout1_o,
   output logic             cout2_o,
   output logic             sum_o,
   output logic             carry_o,
   output logic [ERR_W-1:0] u_err_o
);

   logic [2:0] u0;
   logic [2:0] u1;
   logic [2:0] u2;

   // First level: two cells on the raw column bits.
   assign u0 = apx42(x_i[U0_LSB +: CMP_W]);
   assign u1 = apx42(x_i[U1_LSB +: CMP_W]);

   // Second level: U2 combines both partial sums with the incoming carries.
   assign u2 = apx42({cin2_i, cin1_i, u1[1], u0[1]});

   assign cout1_o = u0[0];
   assign cout2_o = u1[0];
   assign sum_o   = u2[1];
   assign carry_o = u2[0];

   always_comb begin
      u_err_o         = '0;
      u_err_o[ERR_U0] = u0[2];
      u_err_o[ERR_U1] = u1[2];
      u_err_o[ERR_U2] = u2[2];
   end

endmodule

// File: rtl/rt8_col_seq.sv
// Column-serial scheduler for one approximate 8-input reduction slice.
// Accepts LSB-first columns, chains cout1/cout2 into the next column,
// appends one flush column per frame and reports per-frame error counts.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_valid/s_ready/s_col/s_last  input column handshake
//   m_valid/m_ready               output column handshake
//   m_sum, m_carry, m_err, m_last per-column result, m_last on flush column
//   err_cnt, err_cnt_vld          errored columns of last frame + update pulse
//   ovf                           sticky frame-length overflow
module rt8_col_seq
   import rt8_seq_pkg::*;
#(
   parameter int unsigned MAX_COL = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [COL_W-1:0] s_col,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_sum,
   output logic             m_carry,
   output logic [ERR_W-1:0] m_err,
   output logic             m_last,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_cnt_vld,
   output logic             ovf
);

   // Counter must reach MAX_COL+1 before the frame is forced to flush.
   localparam int unsigned CC_W = $clog2(MAX_COL + 2);

   state_e             state_q, state_d;
   logic               m_valid_q, m_valid_d;
   logic               m_sum_q, m_sum_d;
   logic               m_carry_q, m_carry_d;
   logic [ERR_W-1:0]   m_err_q, m_err_d;
   logic               m_last_q, m_last_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic               err_cnt_vld_q, err_cnt_vld_d;
   logic               ovf_q, ovf_d;
   logic               cin1_q, cin1_d;
   logic               cin2_q, cin2_d;
   logic [CC_W-1:0]    col_cnt_q, col_cnt_d;
   logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;

   logic [COL_W-1:0]   slice_x;
   logic               cout1, cout2, sl_sum, sl_carry;
   logic [ERR_W-1:0]   u_err;
   logic               load;
   logic               accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
      return (inc && (v != '1)) ? v + CNT_W'(1) : v;
   endfunction

   // Flush column is an all-zero column carrying only the pending cin.
   assign slice_x = (state_q == FLUSH) ? '0 : s_col;

   rt8_apx_slice u_slice (
      .x_i     (slice_x),
      .cin1_i  (cin1_q),
      .cin2_i  (cin2_q),
      .cout1_o (cout1),
      .cout2_o (cout2),
      .sum_o   (sl_sum),
      .carry_o (sl_carry),
      .u_err_o (u_err)
   );

   assign load    = !m_valid_q || m_ready;
   assign s_ready = (state_q == RUN) && load;
   assign accept  = s_valid && s_ready;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         m_valid_q     <= 1'b0;
         m_sum_q       <= 1'b0;
         m_carry_q     <= 1'b0;
         m_err_q       <= '0;
         m_last_q      <= 1'b0;
         err_cnt_q     <= '0;
         err_cnt_vld_q <= 1'b0;
         ovf_q         <= 1'b0;
         cin1_q        <= 1'b0;
         cin2_q        <= 1'b0;
         col_cnt_q     <= '0;
         run_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         m_valid_q     <= m_valid_d;
         m_sum_q       <= m_sum_d;
         m_carry_q     <= m_carry_d;
         m_err_q       <= m_err_d;
         m_last_q      <= m_last_d;
         err_cnt_q     <= err_cnt_d;
         err_cnt_vld_q <= err_cnt_vld_d;
         ovf_q         <= ovf_d;
         cin1_q        <= cin1_d;
         cin2_q        <= cin2_d;
         col_cnt_q     <= col_cnt_d;
         run_cnt_q     <= run_cnt_d;
      end
   end

   // Next-state and output-register logic.
   always_comb begin
      state_d       = state_q;
      m_valid_d     = m_valid_q;
      m_sum_d       = m_sum_q;
      m_carry_d     = m_carry_q;
      m_err_d       = m_err_q;
      m_last_d      = m_last_q;
      err_cnt_d     = err_cnt_q;
      err_cnt_vld_d = 1'b0;
      ovf_d         = ovf_q;
      cin1_d        = cin1_q;
      cin2_d        = cin2_q;
      col_cnt_d     = col_cnt_q;
      run_cnt_d     = run_cnt_q;

      // A consumed or empty output register drains unless reloaded below.
      if (load) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         RUN: begin
            if (accept) begin
               m_valid_d = 1'b1;
               m_sum_d   = sl_sum;
               m_carry_d = sl_carry;
               m_err_d   = u_err;
               m_last_d  = 1'b0;
               cin1_d    = cout1;
               cin2_d    = cout2;
               col_cnt_d = col_cnt_q + CC_W'(1);
               run_cnt_d = sat_inc(run_cnt_q, |u_err);
               // The (MAX_COL+1)th column is forced to close the frame.
               if (col_cnt_q == CC_W'(MAX_COL)) begin
                  ovf_d   = 1'b1;
                  state_d = FLUSH;
               end else if (s_last) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (load) begin
               m_valid_d = 1'b1;
               m_sum_d   = sl_sum;
               m_carry_d = sl_carry;
               m_err_d   = u_err;
               m_last_d  = 1'b1;
               cin1_d    = 1'b0;
               cin2_d    = 1'b0;
               col_cnt_d = '0;
               run_cnt_d = sat_inc(run_cnt_q, |u_err);
               state_d   = DONE;
            end
         end
         DONE: begin
            err_cnt_d     = run_cnt_q;
            err_cnt_vld_d = 1'b1;
            run_cnt_d     = '0;
            state_d       = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign m_valid     = m_valid_q;
   assign m_sum       = m_sum_q;
   assign m_carry     = m_carry_q;
   assign m_err       = m_err_q;
   assign m_last      = m_last_q;
   assign err_cnt     = err_cnt_q;
   assign err_cnt_vld = err_cnt_vld_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_rt8_col_seq.sv
// Self-checking bench for rt8_col_seq: directed frames plus random frames,
// compared against a column-level reference model. Instance 0 uses the
// default MAX_COL=16, instance 1 uses MAX_COL=400 for counter saturation.
module tb_rt8_col_seq;

   localparam int unsigned SAT_MAX = 255;

   logic        clk;
   logic        rst;
   logic [1:0]  s_valid;
   logic [1:0]  s_last;
   logic [1:0]  m_ready;
   logic [7:0]  s_col [2];
   wire  [1:0]  s_ready;
   wire  [1:0]  m_valid;
   wire  [1:0]  m_sum;
   wire  [1:0]  m_carry;
   wire  [2:0]  m_err [2];
   wire  [1:0]  m_last;
   wire  [7:0]  err_cnt [2];
   wire  [1:0]  err_cnt_vld;
   wire  [1:0]  ovf;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  frm_col [512];
   logic [5:0]  exp_q [$];
   int          exp_cnt;
   logic [31:0] last_cnt;

   rt8_col_seq #(.MAX_COL(16), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_col(s_col[0]), .s_last(s_last[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_sum(m_sum[0]), .m_carry(m_carry[0]),
      .m_err(m_err[0]), .m_last(m_last[0]), .err_cnt(err_cnt[0]),
      .err_cnt_vld(err_cnt_vld[0]), .ovf(ovf[0])
   );

   rt8_col_seq #(.MAX_COL(400), .CNT_W(8)) u_dut_sat (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_col(s_col[1]), .s_last(s_last[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_sum(m_sum[1]), .m_carry(m_carry[1]),
      .m_err(m_err[1]), .m_last(m_last[1]), .err_cnt(err_cnt[1]),
      .err_cnt_vld(err_cnt_vld[1]), .ovf(ovf[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference 4:2 cell from the pair/ones-count rules; returns {err, summ, carry}.
   function automatic logic [2:0] ref42(input logic [3:0] x);
      int a, b, ones;
      logic e, s, c;
      a    = int'(x[0]) + int'(x[1]);
      b    = int'(x[2]) + int'(x[3]);
      ones = a + b;
      e    = (ones == 4);
      s    = ((ones % 2) == 1) || e;
      c    = ((a == 1) && (b == 1)) || ((a == 2) != (b == 2)) || e;
      return {e, s, c};
   endfunction

   // Build expected output columns {sum,carry,err[2:0],last} and err_cnt for a frame.
   task automatic model_frame(input int n, input int max_col);
      logic       c1, c2;
      logic [2:0] u0, u1, u2, e;
      int         neff;
      exp_q.delete();
      c1 = 1'b0; c2 = 1'b0; exp_cnt = 0;
      neff = (n > max_col) ? max_col + 1 : n;
      for (int i = 0; i < neff; i++) begin
         u0 = ref42(frm_col[i][3:0]);
         u1 = ref42(frm_col[i][7:4]);
         u2 = ref42({c2, c1, u1[1], u0[1]});
         e  = {u0[2], u1[2], u2[2]};
         exp_q.push_back({u2[1], u2[0], e, 1'b0});
         c1 = u0[0]; c2 = u1[0];
         if (e != 3'b000 && exp_cnt < SAT_MAX) exp_cnt++;
      end
      u2 = ref42({c2, c1, 2'b00});
      exp_q.push_back({u2[1], u2[0], 2'b00, u2[2], 1'b1});
      if (u2[2] && exp_cnt < SAT_MAX) exp_cnt++;
   endtask

   // Drive one frame into instance sel and check every output column and err_cnt.
   // rdy_mode: 0 = always ready, 1 = toggle each cycle, 2 = random.
   task automatic run_frame(input int sel, input int n, input bit use_last,
                            input int rdy_mode, input bit gaps);
      int         idx, cyc;
      bit         vld_seen, vld_prev, vld_now, stall_prev;
      logic [5:0] cur, prev, exp;
      model_frame(n, (sel == 1) ? 400 : 16);
      idx = 0; cyc = 0; vld_seen = 0; vld_prev = 0; stall_prev = 0; prev = '0;
      while (1) begin
         @(negedge clk);
         cyc++;
         cur = {m_sum[sel], m_carry[sel], m_err[sel], m_last[sel]};
         if (stall_prev) check("hold_stable", 32'(cur), 32'(prev));
         vld_now = err_cnt_vld[sel];
         if (vld_now) begin
            check("vld_one_cycle", 32'(vld_prev), 32'd0);
            check("err_cnt", 32'(err_cnt[sel]), 32'(exp_cnt));
            last_cnt = 32'(err_cnt[sel]);
            vld_seen = 1;
         end
         vld_prev = vld_now;
         case (rdy_mode)
            0:       m_ready[sel] = 1'b1;
            1:       m_ready[sel] = cyc[0];
            default: m_ready[sel] = ($urandom_range(0, 2) != 0);
         endcase
         if (idx < n) begin
            s_valid[sel] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_col[sel]   = frm_col[idx];
            s_last[sel]  = use_last && (idx == n - 1);
         end else begin
            s_valid[sel] = 1'b0;
            s_last[sel]  = 1'b0;
         end
         #1;
         if (m_valid[sel] && m_ready[sel]) begin
            if (exp_q.size() == 0) begin
               check("extra_output", 32'd1, 32'd0);
            end else begin
               exp = exp_q.pop_front();
               check("out_col", 32'(cur), 32'(exp));
            end
         end
         stall_prev = m_valid[sel] && !m_ready[sel];
         prev = cur;
         if (s_valid[sel] && s_ready[sel]) idx++;
         if (exp_q.size() == 0 && vld_seen && !vld_now) break;
         if (cyc > 3000) begin
            check("frame_timeout", 32'd1, 32'd0);
            break;
         end
      end
      m_ready[sel] = 1'b1;
   endtask

   initial begin
      int n, acc, guard;
      rst = 1'b1; s_valid = '0; s_last = '0; m_ready = 2'b11;
      s_col[0] = '0; s_col[1] = '0; last_cnt = '0;
      repeat (3) @(negedge clk);
      check("rst_m_valid", 32'(m_valid[0]), 32'd0);
      check("rst_m_last", 32'(m_last[0]), 32'd0);
      check("rst_err_cnt", 32'(err_cnt[0]), 32'd0);
      check("rst_err_cnt_vld", 32'(err_cnt_vld[0]), 32'd0);
      check("rst_ovf", 32'(ovf[0]), 32'd0);
      rst = 1'b0;

      // Single 8'hFF column.
      frm_col[0] = 8'hFF;
      run_frame(0, 1, 1, 0, 0);
      check("ff_err_cnt_const", last_cnt, 32'd1);

      // Single 8'h03 column.
      frm_col[0] = 8'h03;
      run_frame(0, 1, 1, 0, 0);
      check("h03_err_cnt_const", last_cnt, 32'd0);

      // Four columns with m_ready toggling every cycle.
      frm_col[0] = 8'h00; frm_col[1] = 8'h0F; frm_col[2] = 8'hF0; frm_col[3] = 8'h00;
      run_frame(0, 4, 1, 1, 0);
      check("four_col_err_cnt_const", last_cnt, 32'd2);

      // Random frames, random backpressure and input gaps.
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) frm_col[i] = 8'($urandom);
         run_frame(0, n, 1, 2, 1);
      end
      check("ovf_before", 32'(ovf[0]), 32'd0);

      // 17 columns without s_last: forced flush after the 17th.
      for (int i = 0; i < 17; i++) frm_col[i] = 8'($urandom);
      run_frame(0, 17, 0, 0, 0);
      check("ovf_set", 32'(ovf[0]), 32'd1);

      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) frm_col[i] = 8'($urandom);
      run_frame(0, n, 1, 2, 0);
      check("ovf_sticky", 32'(ovf[0]), 32'd1);

      // Reset after two of four columns.
      acc = 0; guard = 0;
      while (acc < 2 && guard < 50) begin
         @(negedge clk);
         guard++;
         s_valid[0] = 1'b1; s_col[0] = 8'hFF; s_last[0] = 1'b0;
         #1;
         if (s_ready[0]) acc++;
      end
      check("pre_rst_accepts", 32'(acc), 32'd2);
      @(negedge clk);
      s_valid[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_m_valid", 32'(m_valid[0]), 32'd0);
      check("mid_rst_s_ready", 32'(s_ready[0]), 32'd1);
      check("mid_rst_err_cnt", 32'(err_cnt[0]), 32'd0);
      check("mid_rst_vld", 32'(err_cnt_vld[0]), 32'd0);
      check("mid_rst_ovf", 32'(ovf[0]), 32'd0);

      frm_col[0] = 8'h03;
      run_frame(0, 1, 1, 0, 0);
      check("post_rst_err_cnt_const", last_cnt, 32'd0);

      // Run-counter saturation on the MAX_COL=400 instance.
      for (int i = 0; i < 300; i++) frm_col[i] = 8'hFF;
      run_frame(1, 300, 1, 0, 0);
      check("sat_err_cnt_const", last_cnt, 32'd255);
      check("sat_no_ovf", 32'(ovf[1]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
